// File: rtl/data_mem_pkg.sv
// Shared types and default sizes for the sweeping data memory.
package data_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    PRESET0 = 2'd1,
    PRESET1 = 2'd2,
    READY   = 2'd3
  } sweep_state_t;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 8;

endpackage

// File: rtl/data_mem_sweep_if.sv
// User-side bus of the data memory: one shared pointer for read and write.
interface data_mem_sweep_if
  import data_mem_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic          WriteEn;
  logic          ReadEn;
  logic [AW-1:0] DataAddress;
  logic [DW-1:0] DataIn;
  logic          ClearReq;
  logic [DW-1:0] DataOut;
  logic          DataValid;
  logic          Ready;

  modport master (
    output WriteEn, ReadEn, DataAddress, DataIn, ClearReq,
    input  DataOut, DataValid, Ready
  );

  modport slave (
    input  WriteEn, ReadEn, DataAddress, DataIn, ClearReq,
    output DataOut, DataValid, Ready
  );

endinterface

// File: rtl/data_mem_sweep_fsm.sv
// Sweep sequencer: clears every word, plants two constants, then hands the
// array to the user by raising Ready.
module data_mem_sweep_fsm
  import data_mem_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int DEPTH   = 2**AW,
  parameter int P0_ADDR = 16,
  parameter int P0_VAL  = 254,
  parameter int P1_ADDR = 244,
  parameter int P1_VAL  = 5
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          i_clear_req,
  output logic          o_ready,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  // One bit wider than the address so DEPTH = 2**AW ends without wrapping.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  sweep_state_t r_state, w_state_nxt;
  logic [AW:0]  r_cnt, w_cnt_nxt;
  logic         r_ready, w_ready_nxt;

  // State, counter and Ready registers.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Next state and the internal write port.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    o_we        = 1'b0;
    o_addr      = '0;
    o_data      = '0;
    case (r_state)
      CLEAR: begin
        o_we        = 1'b1;
        o_addr      = r_cnt[AW-1:0];
        w_ready_nxt = 1'b0;
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = PRESET0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + (AW+1)'(1);
        end
      end
      PRESET0: begin
        o_we        = 1'b1;
        o_addr      = AW'(P0_ADDR);
        o_data      = DW'(P0_VAL);
        w_state_nxt = PRESET1;
      end
      PRESET1: begin
        // Written last, so P1 wins if both presets share an address.
        o_we        = 1'b1;
        o_addr      = AW'(P1_ADDR);
        o_data      = DW'(P1_VAL);
        w_state_nxt = READY;
        w_ready_nxt = 1'b1;
      end
      READY: begin
        if (i_clear_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
          w_ready_nxt = 1'b0;
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_cnt_nxt   = '0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  assign o_ready = r_ready;

endmodule

// File: rtl/data_mem_sweep.sv
// Parametrised single-pointer data memory with self-clearing sweep and a
// Ready flag gating all user access.
module data_mem_sweep
  import data_mem_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int DEPTH   = 2**AW,
  parameter int RD_LAT  = 0,
  parameter int P0_ADDR = 16,
  parameter int P0_VAL  = 254,
  parameter int P1_ADDR = 244,
  parameter int P1_VAL  = 5
) (
  input logic             Clk,
  input logic             ResetN,
  data_mem_sweep_if.slave bus
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] r_core [0:DEPTH-1];

  logic          w_ready;
  logic          w_fsm_we;
  logic [AW-1:0] w_fsm_addr;
  logic [DW-1:0] w_fsm_data;
  logic          w_user_we;
  logic          w_we;
  logic [AW-1:0] w_wr_addr;
  logic [DW-1:0] w_wr_data;
  logic          w_wr_in_range;
  logic          w_rd_in_range;
  logic [DW-1:0] w_rd_data;

  data_mem_sweep_fsm #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH),
    .P0_ADDR(P0_ADDR), .P0_VAL(P0_VAL),
    .P1_ADDR(P1_ADDR), .P1_VAL(P1_VAL)
  ) u_fsm (
    .Clk         (Clk),
    .ResetN      (ResetN),
    .i_clear_req (bus.ClearReq),
    .o_ready     (w_ready),
    .o_we        (w_fsm_we),
    .o_addr      (w_fsm_addr),
    .o_data      (w_fsm_data)
  );

  // Sweep and user never write in the same cycle; ClearReq drops a user write.
  assign w_user_we     = bus.WriteEn & w_ready & ~bus.ClearReq;
  assign w_we          = w_fsm_we | w_user_we;
  assign w_wr_addr     = w_fsm_we ? w_fsm_addr : bus.DataAddress;
  assign w_wr_data     = w_fsm_we ? w_fsm_data : bus.DataIn;
  assign w_wr_in_range = ({1'b0, w_wr_addr} < DEPTH_W);
  assign w_rd_in_range = ({1'b0, bus.DataAddress} < DEPTH_W);
  assign w_rd_data     = w_rd_in_range ? r_core[bus.DataAddress] : '0;

  // Storage array; contents are established by the sweep, not by reset.
  always_ff @(posedge Clk) begin
    if (w_we && w_wr_in_range) begin
      r_core[w_wr_addr] <= w_wr_data;
    end
  end

  assign bus.Ready = w_ready;

  generate
    if (RD_LAT == 0) begin : g_comb_rd
      assign bus.DataOut   = w_ready ? w_rd_data : '0;
      assign bus.DataValid = bus.ReadEn & w_ready;
    end else begin : g_reg_rd
      logic [DW-1:0] r_dout;
      logic          r_valid;

      // Registered read port; sampling before the array update gives read-first.
      always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end else if (bus.ReadEn && w_ready) begin
          r_dout  <= w_rd_data;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end

      assign bus.DataOut   = r_dout;
      assign bus.DataValid = r_valid;
    end
  endgenerate

endmodule
